// File: rtl/ascon_pkg.sv
// Shared Ascon types, round constants and FSM encodings for the
// finalization engine and its round datapath.
package ascon_pkg;

    localparam int LANE_W    = 64;
    localparam int ROUNDS_PA = 12;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    typedef logic [LANE_W-1:0] lane_t;

    typedef struct packed {
        lane_t x0;
        lane_t x1;
        lane_t x2;
        lane_t x3;
        lane_t x4;
    } ascon_state_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PERM = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // p12 constants, index 0 first; top four slots pad to a 4-bit index
    localparam logic [15:0][7:0] RC = {
        8'h00, 8'h00, 8'h00, 8'h00,
        8'h4b, 8'h5a, 8'h69, 8'h78,
        8'h87, 8'h96, 8'ha5, 8'hb4,
        8'hc3, 8'hd2, 8'he1, 8'hf0
    };

    function automatic lane_t ror(input lane_t v, input int unsigned n);
        return (v >> n) | (v << (LANE_W - n));
    endfunction

endpackage

// File: rtl/ascon_finalization_iter_round.sv
// One Ascon permutation round: constant addition, bitsliced 5-bit
// S-box layer and the per-lane linear diffusion layer.
module ascon_round
    import ascon_pkg::*;
(
    input  ascon_state_t s_i,
    input  logic [7:0]   rc_i,
    output ascon_state_t s_o
);

    lane_t x0, x1, x2, x3, x4;
    lane_t t0, t1, t2, t3, t4;

    always_comb begin
        x0 = s_i.x0;
        x1 = s_i.x1;
        x2 = s_i.x2 ^ {{(LANE_W-8){1'b0}}, rc_i};
        x3 = s_i.x3;
        x4 = s_i.x4;

        x0 ^= x4;
        x4 ^= x3;
        x2 ^= x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 ^= t1;
        x1 ^= t2;
        x2 ^= t3;
        x3 ^= t4;
        x4 ^= t0;
        x1 ^= x0;
        x0 ^= x4;
        x3 ^= x2;
        x2 = ~x2;

        s_o.x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
        s_o.x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
        s_o.x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
        s_o.x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
        s_o.x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
    end

endmodule

// File: rtl/ascon_finalization_iter.sv
// Iterative Ascon finalization: key injection, p12 over UNROLL rounds
// per cycle, tag extraction and constant-time tag compare.
module ascon_finalization_iter
    import ascon_pkg::*;
#(
    parameter int RATE_W = 128,
    parameter int UNROLL = 1,
    parameter int TAG_W  = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic [127:0]     key,
    input  logic [63:0]      x0_i,
    input  logic [63:0]      x1_i,
    input  logic [63:0]      x2_i,
    input  logic [63:0]      x3_i,
    input  logic [63:0]      x4_i,
    input  logic [TAG_W-1:0] tag_exp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TAG_W-1:0] tag,
    output logic             tag_ok,
    output logic             busy
);

    localparam int         STEPS = ROUNDS_PA / UNROLL;
    localparam logic [3:0] LAST  = 4'(STEPS - 1);
    localparam logic [3:0] UN4   = 4'(UNROLL);

    if (!(UNROLL inside {1, 2, 3, 4, 6, 12})) begin : g_bad_unroll
        $error("ascon_finalization_iter: illegal UNROLL");
    end
    if (!(RATE_W inside {64, 128})) begin : g_bad_rate
        $error("ascon_finalization_iter: illegal RATE_W");
    end
    if (TAG_W < 64 || TAG_W > 128) begin : g_bad_tag
        $error("ascon_finalization_iter: illegal TAG_W");
    end

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    ascon_state_t      st_q, st_d;
    logic [127:0]      key_q, key_d;
    logic              mode_q, mode_d;
    logic [TAG_W-1:0]  texp_q, texp_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              ok_q, ok_d;

    ascon_state_t      inj;
    ascon_state_t      chain [UNROLL+1];
    logic [127:0]      tag_full;
    logic [TAG_W-1:0]  tag_calc;

    always_comb begin
        inj = '{x0: x0_i, x1: x1_i, x2: x2_i, x3: x3_i, x4: x4_i};
        if (RATE_W == 64) begin
            inj.x1 ^= key[127:64];
            inj.x2 ^= key[63:0];
        end else begin
            inj.x2 ^= key[127:64];
            inj.x3 ^= key[63:0];
        end
    end

    assign chain[0] = st_q;

    for (genvar i = 0; i < UNROLL; i++) begin : g_round
        logic [3:0] idx;
        assign idx = 4'(cnt_q * UN4 + 4'(i));
        ascon_round u_round (
            .s_i  (chain[i]),
            .rc_i (RC[idx]),
            .s_o  (chain[i+1])
        );
    end

    assign tag_full = {chain[UNROLL].x3 ^ key_q[127:64],
                       chain[UNROLL].x4 ^ key_q[63:0]};
    assign tag_calc = tag_full[127 -: TAG_W];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        st_d    = st_q;
        key_d   = key_q;
        mode_d  = mode_q;
        texp_d  = texp_q;
        tag_d   = tag_q;
        ok_d    = ok_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    state_d = ST_PERM;
                    cnt_d   = '0;
                    st_d    = inj;
                    key_d   = key;
                    mode_d  = mode;
                    texp_d  = (mode == MODE_DEC) ? tag_exp : '0;
                end
            end
            ST_PERM: begin
                st_d = chain[UNROLL];
                if (cnt_q == LAST) begin
                    // XOR-OR reduction keeps the compare data-independent
                    tag_d   = tag_calc;
                    ok_d    = mode_q & ~(|(tag_calc ^ texp_q));
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    st_d    = '0;
                    key_d   = '0;
                    mode_d  = MODE_ENC;
                    texp_d  = '0;
                    tag_d   = '0;
                    ok_d    = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            st_q    <= '0;
            key_q   <= '0;
            mode_q  <= MODE_ENC;
            texp_q  <= '0;
            tag_q   <= '0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            st_q    <= st_d;
            key_q   <= key_d;
            mode_q  <= mode_d;
            texp_q  <= texp_d;
            tag_q   <= tag_d;
            ok_q    <= ok_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE) && !rst;
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign tag       = tag_q;
    assign tag_ok    = ok_q;

endmodule

// File: tb/tb_ascon_finalization_iter.sv
// Directed and random checks of the finalization engine against a
// column-wise S-box-table model of Ascon p12 finalization.
module tb_ascon_finalization_iter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic         a_in_valid, a_in_ready, a_mode, a_out_valid, a_out_ready;
    logic         a_tag_ok, a_busy;
    logic [127:0] a_key, a_texp, a_tag;
    logic [63:0]  a_x0, a_x1, a_x2, a_x3, a_x4;

    logic         b_in_valid, b_in_ready, b_mode, b_out_valid, b_out_ready;
    logic         b_tag_ok, b_busy;
    logic [127:0] b_key;
    logic [63:0]  b_texp, b_tag;
    logic [63:0]  b_x0, b_x1, b_x2, b_x3, b_x4;

    ascon_finalization_iter #(.RATE_W(128), .UNROLL(1), .TAG_W(128)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .mode(a_mode),
        .key(a_key), .x0_i(a_x0), .x1_i(a_x1), .x2_i(a_x2),
        .x3_i(a_x3), .x4_i(a_x4), .tag_exp(a_texp),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .tag(a_tag), .tag_ok(a_tag_ok), .busy(a_busy)
    );

    ascon_finalization_iter #(.RATE_W(64), .UNROLL(3), .TAG_W(64)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .mode(b_mode),
        .key(b_key), .x0_i(b_x0), .x1_i(b_x1), .x2_i(b_x2),
        .x3_i(b_x3), .x4_i(b_x4), .tag_exp(b_texp),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .tag(b_tag), .tag_ok(b_tag_ok), .busy(b_busy)
    );

    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };
    localparam int ROT1 [5] = '{19, 61, 1, 10, 7};
    localparam int ROT2 [5] = '{28, 39, 6, 17, 41};

    task automatic chk(input string nm, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
        end
    endtask

    function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
        logic [63:0] r;
        for (int j = 0; j < 64; j++) r[j] = v[(j + n) % 64];
        return r;
    endfunction

    function automatic logic [127:0] ref_tag(input int rate,
                                             input logic [127:0] k,
                                             input logic [319:0] s);
        logic [63:0] x [5];
        logic [4:0]  col, o;
        for (int i = 0; i < 5; i++) x[i] = s[319 - 64*i -: 64];
        if (rate == 64) begin
            x[1] ^= k[127:64];
            x[2] ^= k[63:0];
        end else begin
            x[2] ^= k[127:64];
            x[3] ^= k[63:0];
        end
        for (int r = 0; r < 12; r++) begin
            x[2][7:0] ^= 8'(240 - 15 * r);
            for (int b = 0; b < 64; b++) begin
                col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
                o = SBOX[col];
                x[0][b] = o[4];
                x[1][b] = o[3];
                x[2][b] = o[2];
                x[3][b] = o[1];
                x[4][b] = o[0];
            end
            for (int i = 0; i < 5; i++)
                x[i] = x[i] ^ rotr(x[i], ROT1[i]) ^ rotr(x[i], ROT2[i]);
        end
        return {x[3] ^ k[127:64], x[4] ^ k[63:0]};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [319:0] rnd320();
        logic [319:0] v;
        for (int i = 0; i < 10; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    task automatic xact_a(input logic m, input logic [127:0] k,
                          input logic [319:0] s, input logic [127:0] texp,
                          input int hold, input string nm);
        logic [127:0] e;
        int lat;
        e = ref_tag(128, k, s);
        a_mode = m;
        a_key = k;
        {a_x0, a_x1, a_x2, a_x3, a_x4} = s;
        a_texp = texp;
        a_in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_in_valid = 1'b0;
        a_key = rnd128();
        a_texp = rnd128();
        {a_x0, a_x1, a_x2, a_x3, a_x4} = rnd320();
        lat = 1;
        while (!a_out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, ":lat"}, 128'(lat), 128'd13);
        chk({nm, ":tag"}, a_tag, e);
        chk({nm, ":ok"}, 128'(a_tag_ok), 128'(m && (e == texp)));
        a_in_valid = (hold > 0);
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            chk({nm, ":hold_tag"}, a_tag, e);
            chk({nm, ":hold_rdy"}, 128'({a_in_ready, a_out_valid}), 128'd1);
        end
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        @(negedge clk);
        a_out_ready = 1'b0;
        chk({nm, ":clr_tag"}, a_tag, 128'd0);
        chk({nm, ":clr_flags"},
            128'({a_in_ready, a_out_valid, a_busy, a_tag_ok}), 128'b1000);
    endtask

    task automatic xact_b(input logic m, input logic [127:0] k,
                          input logic [319:0] s, input logic [63:0] texp,
                          input string nm);
        logic [127:0] e;
        int lat;
        e = ref_tag(64, k, s);
        b_mode = m;
        b_key = k;
        {b_x0, b_x1, b_x2, b_x3, b_x4} = s;
        b_texp = texp;
        b_in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b_in_valid = 1'b0;
        b_key = rnd128();
        lat = 1;
        while (!b_out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, ":lat"}, 128'(lat), 128'd5);
        chk({nm, ":tag"}, 128'(b_tag), 128'(e[127:64]));
        chk({nm, ":ok"}, 128'(b_tag_ok), 128'(m && (e[127:64] == texp)));
        b_out_ready = 1'b1;
        @(negedge clk);
        b_out_ready = 1'b0;
        chk({nm, ":clr"}, 128'({b_in_ready, b_tag}), {63'd0, 1'b1, 64'd0});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [127:0] gold, k, e, tx;
        logic [319:0] s;
        logic         m;

        rst = 1'b1;
        a_in_valid = 0; a_mode = 0; a_key = '0; a_texp = '0; a_out_ready = 0;
        {a_x0, a_x1, a_x2, a_x3, a_x4} = '0;
        b_in_valid = 0; b_mode = 0; b_key = '0; b_texp = '0; b_out_ready = 0;
        {b_x0, b_x1, b_x2, b_x3, b_x4} = '0;

        @(negedge clk);
        a_in_valid = 1'b1;
        @(negedge clk);
        chk("rst_a", 128'({a_out_valid, a_busy, a_tag_ok}), 128'd0);
        chk("rst_a_tag", a_tag, 128'd0);
        chk("rst_b", 128'({b_out_valid, b_busy, b_tag_ok, b_tag}), 128'd0);
        a_in_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_rdy", 128'({a_in_ready, b_in_ready}), 128'b11);
        chk("rst_nobusy", 128'(a_busy), 128'd0);
        @(negedge clk);

        gold = ref_tag(128, '0, '0);
        xact_a(1'b0, '0, '0, '0, 0, "zero_enc");
        xact_a(1'b1, '0, '0, gold, 0, "dec_match");
        xact_a(1'b1, '0, '0, gold ^ 128'd1, 0, "dec_flip0");
        xact_a(1'b0, rnd128(), rnd320(), rnd128(), 20, "backpressure");

        a_mode = 1'b0;
        a_key = rnd128();
        {a_x0, a_x1, a_x2, a_x3, a_x4} = rnd320();
        a_in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst", 128'({a_busy, a_out_valid}), 128'd0);
        chk("midrst_tag", a_tag, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_rdy", 128'(a_in_ready), 128'd1);
        repeat (15) @(negedge clk);
        chk("midrst_quiet", 128'({a_busy, a_out_valid}), 128'd0);
        xact_a(1'b0, '0, '0, '0, 0, "post_rst");

        for (int i = 0; i < 30; i++) begin
            k = rnd128();
            s = rnd320();
            m = 1'($urandom_range(0, 1));
            e = ref_tag(128, k, s);
            tx = ($urandom_range(0, 1) == 1) ? e
                 : e ^ (128'd1 << $urandom_range(0, 127));
            xact_a(m, k, s, tx, 0, "rand_a");
        end

        xact_b(1'b0, '0, '0, '0, "b_zero");
        for (int i = 0; i < 200; i++) begin
            k = rnd128();
            s = rnd320();
            m = 1'($urandom_range(0, 1));
            e = ref_tag(64, k, s);
            tx = ($urandom_range(0, 1) == 1) ? e
                 : e ^ (128'd1 << $urandom_range(64, 127));
            xact_b(m, k, s, tx[127:64], "rand_b");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ascon_finalization_iter.md
Name: ascon_finalization_iter

Overview:
- Iterative, parametrised Ascon finalization engine.
- Accepts the post-processing state (x0..x4) and key, applies the key injection for the selected rate, runs p12 on an internal UNROLL-round datapath, then emits the tag.
- In decrypt mode it also compares the computed tag against an expected tag.
- Sits between the datapath's last-block absorb stage and the tag output/verify logic.
- Replaces the external p12 hook-up with a self-contained valid/ready engine.

Parameters:
- RATE_W, 128, rate in bits. 64 = Ascon-128: key XORed into x1/x2. 128 = Ascon-128a: key XORed into x2/x3.
- UNROLL, 1, permutation rounds per cycle. Legal values: 1, 2, 3, 4, 6, 12. Any other value is an elaboration error.
- TAG_W, 128, tag width, 64..128. The tag is the upper TAG_W bits of the full 128-bit tag.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  input request
- in_ready  out  1  engine idle, can accept
- mode  in  1  0 = encrypt (generate tag), 1 = decrypt (verify)
- key  in  128  key; K_hi = key[127:64], K_lo = key[63:0]
- x0_i..x4_i  in  64 each  state entering finalization
- tag_exp  in  TAG_W  expected tag; sampled only when mode=1
- out_valid  out  1  tag/result available
- out_ready  in  1  consumer accepts result
- tag  out  TAG_W  computed tag
- tag_ok  out  1  decrypt: tag == tag_exp; encrypt: 0
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst=1): state IDLE; round counter 0; state regs, tag, tag_ok, out_valid, busy all 0; in_ready=1 once rst deasserts.
- FSM states: IDLE, PERM, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready, register the injected state:
    - RATE_W=64: x1^K_hi, x2^K_lo.
    - RATE_W=128: x2^K_hi, x3^K_lo.
  - Also register key, mode and tag_exp (zero-filled if mode=0).
  - Next state PERM, counter 0.
- PERM:
  - Each cycle applies UNROLL consecutive rounds with constants c[i] = 0xF0 - 0x0F*i for i = cnt*UNROLL .. cnt*UNROLL+UNROLL-1; c is XORed into the low byte of x2.
  - Round = constant add, 5-bit S-box layer, linear layer with rotation pairs: x0 (19,28), x1 (61,39), x2 (1,6), x3 (10,17), x4 (7,41).
  - On the last counter value (12/UNROLL - 1):
    - Compute full tag T = (x3'^K_hi) || (x4'^K_lo), with x3' in T[127:64].
    - Register tag = T[127:128-TAG_W].
    - Register tag_ok = mode & (tag == tag_exp).
    - Next state DONE.
- Latency: in handshake in cycle n gives out_valid=1 in cycle n + 12/UNROLL + 1 (13 cycles for UNROLL=1, 2 cycles for UNROLL=12).
- DONE:
  - out_valid=1; tag and tag_ok held stable while out_ready=0.
  - On out_valid & out_ready: tag, tag_ok and internal state zeroised; go to IDLE.
  - in_ready rises the next cycle. No overlap between output and next input; throughput is one result per 12/UNROLL + 2 cycles minimum.
- in_ready=0 in PERM and DONE. in_valid in those states is ignored; inputs need not be held after acceptance.
- Output stability: out_valid never drops without a handshake. In encrypt mode tag_ok is always 0.
- Comparison is a full-width XOR-OR reduction, not an early-exit compare.
- Reset mid-operation (PERM or DONE): immediate return to IDLE, all registers cleared, no partial output.
- Simultaneous rst and in_valid: reset wins, nothing accepted.

Decomposition:
- Shared package ascon_pkg:
  - round-constant table (12 x 8 bits)
  - lane width 64, ROUNDS_PA = 12
  - mode encodings ENC=0 / DEC=1
  - FSM state encodings
- One combinational sub-module, ascon_round: one round (constant, S-box, linear layer) with an 8-bit constant input.
- ascon_round is instantiated UNROLL times in a chain via a generate loop.
- FSM, counter, key injection, tag extraction and compare stay in ascon_finalization_iter.

Test Plan:
- Ascon-128a vector (RATE_W=128, UNROLL=1, TAG_W=128), all-zero key/state, mode=0 -> out_valid exactly 13 cycles after handshake; tag bit-exact to the golden C model; tag_ok=0.
- Same stimulus with UNROLL=1, 2, 3, 4, 6, 12 -> identical tag; latency 13, 7, 5, 4, 3, 2 cycles respectively.
- Decrypt with tag_exp = golden tag -> tag_ok=1. Same input with tag_exp bit 0 flipped -> tag_ok=0, tag unchanged.
- Backpressure: out_ready=0 for 20 cycles after out_valid -> tag/tag_ok stable, in_ready=0, new in_valid ignored. After out_ready=1: tag=0 and in_ready=1 the following cycle.
- Reset pulse (rst=1 for 1 cycle) during PERM cycle 5 -> busy=0, out_valid=0, tag=0 immediately. A subsequent new request produces the correct golden tag.
- RATE_W=64, TAG_W=64, random key/state (10k vectors) -> tag equals the upper 64 bits of the Ascon-128 golden tag.
